// File: rtl/ball_engine.sv
// Ball physics for the pong datapath: fixed-point position and velocity, wall
// bounces, paddle deflection with progressive speed-up, goal detection and serve timing.
module ball_engine #(
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int FRAC_W       = 4,
  parameter int V_W          = 8,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BORDER       = 10,
  parameter int BALL_SIDE    = 8,
  parameter int SERVE_FRAMES = 60,
  parameter int INIT_SPEED   = 16,
  parameter int SPEED_STEP   = 2,
  parameter int MAX_SPEED    = 64,
  parameter int HITS_PER_UP  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             game_en_i,
  input  logic             new_frame_i,
  input  logic [7:0]       rnd_i,
  input  logic             hit_left_i,
  input  logic             hit_right_i,
  output logic [X_W-1:0]   x_o,
  output logic [Y_W-1:0]   y_o,
  output logic [X_W-1:0]   right_o,
  output logic [Y_W-1:0]   bottom_o,
  output logic             goal_left_o,
  output logic             goal_right_o,
  output logic             serving_o,
  output logic [V_W-2:0]   speed_o
);

  localparam int PX_W  = X_W + FRAC_W;
  localparam int PY_W  = Y_W + FRAC_W;
  localparam int SP_W  = V_W - 1;
  localparam int SRV_W = $clog2(SERVE_FRAMES + 1);
  localparam int HIT_W = $clog2(HITS_PER_UP + 1);

  localparam logic [PX_W-1:0] CENTRE_X = PX_W'(((H_RES - BALL_SIDE) / 2) << FRAC_W);
  localparam logic [PY_W-1:0] CENTRE_Y = PY_W'(((V_RES - BALL_SIDE) / 2) << FRAC_W);
  localparam logic [SP_W-1:0] INIT_SP  = SP_W'(INIT_SPEED);
  localparam logic [V_W-1:0]  INIT_V   = V_W'(INIT_SPEED);

  // The move can never wrap only while one frame's step is smaller than the margin.
  if ((MAX_SPEED >> FRAC_W) >= BORDER) begin : g_bad_speed
    $error("ball_engine: MAX_SPEED >> FRAC_W must be below BORDER");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_GOAL
  } state_e;

  state_e            state_q, state_d;
  logic [PX_W-1:0]   pos_x_q, pos_x_d;
  logic [PY_W-1:0]   pos_y_q, pos_y_d;
  logic [V_W-1:0]    vx_q, vx_d;
  logic [V_W-1:0]    vy_q, vy_d;
  logic [SP_W-1:0]   speed_q, speed_d;
  logic [HIT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [SRV_W-1:0]  srv_cnt_q, srv_cnt_d;
  logic              hit_l_q, hit_l_d, hit_l_prev_q, hit_l_prev_d;
  logic              hit_r_q, hit_r_d, hit_r_prev_q, hit_r_prev_d;
  logic              goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic              serving_q, serving_d;
  logic [X_W-1:0]    right_q, right_d;
  logic [Y_W-1:0]    bottom_q, bottom_d;

  logic [X_W-1:0]    x_int;
  logic [Y_W-1:0]    y_int;
  logic              edge_l, edge_r, hit_one;
  logic [V_W-1:0]    hit_vy_mag, speed_sum;
  logic [SP_W-1:0]   speed_up;
  logic [HIT_W-1:0]  hit_cnt_inc;
  logic              goal_l_det, goal_r_det, wall_top, wall_bot;

  assign x_int = pos_x_q[PX_W-1:FRAC_W];
  assign y_int = pos_y_q[PY_W-1:FRAC_W];

  // Edges come from the registered inputs, so a simultaneous left/right edge cancels.
  assign edge_l  = hit_l_q & ~hit_l_prev_q;
  assign edge_r  = hit_r_q & ~hit_r_prev_q;
  assign hit_one = edge_l ^ edge_r;

  assign hit_vy_mag  = V_W'(rnd_i[6:5]) * V_W'(SPEED_STEP) + V_W'(2);
  assign speed_sum   = {1'b0, speed_q} + V_W'(SPEED_STEP);
  assign speed_up    = (speed_sum > V_W'(MAX_SPEED)) ? SP_W'(MAX_SPEED) : speed_sum[SP_W-1:0];
  assign hit_cnt_inc = hit_cnt_q + HIT_W'(1);

  assign goal_l_det = x_int < X_W'(BORDER);
  assign goal_r_det = ({1'b0, x_int} + (X_W+1)'(BALL_SIDE)) > (X_W+1)'(H_RES - BORDER);
  assign wall_top   = y_int < Y_W'(BORDER);
  assign wall_bot   = ({1'b0, y_int} + (Y_W+1)'(BALL_SIDE)) > (Y_W+1)'(V_RES - BORDER);

  // NOTE: every _d gets its hold value before the case; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    speed_d      = speed_q;
    hit_cnt_d    = hit_cnt_q;
    srv_cnt_d    = srv_cnt_q;
    hit_l_d      = hit_left_i;
    hit_r_d      = hit_right_i;
    hit_l_prev_d = hit_l_q;
    hit_r_prev_d = hit_r_q;
    goal_l_d     = 1'b0;
    goal_r_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pos_x_d   = CENTRE_X;
        pos_y_d   = CENTRE_Y;
        vx_d      = '0;
        vy_d      = '0;
        state_d   = ST_SERVE;
        srv_cnt_d = SRV_W'(SERVE_FRAMES);
      end

      ST_SERVE: begin
        if (new_frame_i) begin
          if (srv_cnt_q == '0) begin
            state_d   = ST_PLAY;
            vx_d      = rnd_i[0] ? (V_W'(0) - INIT_V) : INIT_V;
            vy_d      = rnd_i[4] ? (V_W'(0) - V_W'(rnd_i[3:1])) : V_W'(rnd_i[3:1]);
            hit_cnt_d = '0;
          end else begin
            srv_cnt_d = srv_cnt_q - SRV_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (hit_one) begin
          vx_d = edge_l ? {1'b0, speed_q} : (V_W'(0) - {1'b0, speed_q});
          vy_d = vy_q[V_W-1] ? (V_W'(0) - hit_vy_mag) : hit_vy_mag;
          if (hit_cnt_inc == HIT_W'(HITS_PER_UP)) begin
            hit_cnt_d = '0;
            speed_d   = speed_up;
          end else begin
            hit_cnt_d = hit_cnt_inc;
          end
        end

        if (new_frame_i) begin
          if (goal_l_det || goal_r_det) begin
            state_d  = ST_GOAL;
            goal_l_d = goal_l_det;
            goal_r_d = goal_r_det & ~goal_l_det;
          end else begin
            if ((wall_top && vy_d[V_W-1]) || (wall_bot && !vy_d[V_W-1] && vy_d != '0)) begin
              vy_d = V_W'(0) - vy_d;
            end
            pos_x_d = pos_x_q + {{(PX_W-V_W){vx_d[V_W-1]}}, vx_d};
            pos_y_d = pos_y_q + {{(PY_W-V_W){vy_d[V_W-1]}}, vy_d};
          end
        end
      end

      ST_GOAL: begin
        state_d   = ST_SERVE;
        srv_cnt_d = SRV_W'(SERVE_FRAMES);
        pos_x_d   = CENTRE_X;
        pos_y_d   = CENTRE_Y;
        vx_d      = '0;
        vy_d      = '0;
        speed_d   = INIT_SP;
      end

      default: state_d = ST_IDLE;
    endcase

    if (!game_en_i) begin
      state_d   = ST_IDLE;
      pos_x_d   = CENTRE_X;
      pos_y_d   = CENTRE_Y;
      vx_d      = '0;
      vy_d      = '0;
      speed_d   = INIT_SP;
      hit_cnt_d = '0;
      srv_cnt_d = '0;
      goal_l_d  = 1'b0;
      goal_r_d  = 1'b0;
    end

    serving_d = (state_d == ST_SERVE);
    right_d   = pos_x_d[PX_W-1:FRAC_W] + X_W'(BALL_SIDE);
    bottom_d  = pos_y_d[PY_W-1:FRAC_W] + Y_W'(BALL_SIDE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pos_x_q      <= CENTRE_X;
      pos_y_q      <= CENTRE_Y;
      vx_q         <= '0;
      vy_q         <= '0;
      speed_q      <= INIT_SP;
      hit_cnt_q    <= '0;
      srv_cnt_q    <= '0;
      hit_l_q      <= 1'b0;
      hit_l_prev_q <= 1'b0;
      hit_r_q      <= 1'b0;
      hit_r_prev_q <= 1'b0;
      goal_l_q     <= 1'b0;
      goal_r_q     <= 1'b0;
      serving_q    <= 1'b0;
      right_q      <= CENTRE_X[PX_W-1:FRAC_W] + X_W'(BALL_SIDE);
      bottom_q     <= CENTRE_Y[PY_W-1:FRAC_W] + Y_W'(BALL_SIDE);
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      speed_q      <= speed_d;
      hit_cnt_q    <= hit_cnt_d;
      srv_cnt_q    <= srv_cnt_d;
      hit_l_q      <= hit_l_d;
      hit_l_prev_q <= hit_l_prev_d;
      hit_r_q      <= hit_r_d;
      hit_r_prev_q <= hit_r_prev_d;
      goal_l_q     <= goal_l_d;
      goal_r_q     <= goal_r_d;
      serving_q    <= serving_d;
      right_q      <= right_d;
      bottom_q     <= bottom_d;
    end
  end

  assign x_o          = x_int;
  assign y_o          = y_int;
  assign right_o      = right_q;
  assign bottom_o     = bottom_q;
  assign goal_left_o  = goal_l_q;
  assign goal_right_o = goal_r_q;
  assign serving_o    = serving_q;
  assign speed_o      = speed_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: a default-size instance plus a short-screen
// instance (V_RES 48) sharing the same stimulus, used for the wall bounce.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_en = 1'b0;
  logic       new_frame = 1'b0;
  logic [7:0] rnd = 8'h00;
  logic       hit_left = 1'b0;
  logic       hit_right = 1'b0;

  logic [9:0] x, y, right, bottom;
  logic       goal_l, goal_r, serving;
  logic [6:0] speed;

  logic [9:0] w_x, w_y, w_right, w_bottom;
  logic       w_goal_l, w_goal_r, w_serving;
  logic [6:0] w_speed;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ball_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .game_en_i(game_en), .new_frame_i(new_frame),
    .rnd_i(rnd), .hit_left_i(hit_left), .hit_right_i(hit_right),
    .x_o(x), .y_o(y), .right_o(right), .bottom_o(bottom),
    .goal_left_o(goal_l), .goal_right_o(goal_r), .serving_o(serving), .speed_o(speed)
  );

  ball_engine #(.V_RES(48)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .game_en_i(game_en), .new_frame_i(new_frame),
    .rnd_i(rnd), .hit_left_i(hit_left), .hit_right_i(hit_right),
    .x_o(w_x), .y_o(w_y), .right_o(w_right), .bottom_o(w_bottom),
    .goal_left_o(w_goal_l), .goal_right_o(w_goal_r), .serving_o(w_serving), .speed_o(w_speed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One-cycle strobe; returns at the negedge right after the strobed posedge.
  task automatic frame();
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
  endtask

  task automatic hit(input bit left, input int hold);
    if (left) hit_left = 1'b1;
    else      hit_right = 1'b1;
    repeat (hold) @(negedge clk);
    hit_left  = 1'b0;
    hit_right = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Restart from IDLE and launch with the given random bits.
  task automatic serve(input logic [7:0] r);
    game_en = 1'b0;
    @(negedge clk);
    game_en = 1'b1;
    @(negedge clk);
    repeat (60) frame();
    rnd = r;
    frame();
    rnd = 8'h00;
  endtask

  initial begin
    int not_serving;
    int y_min;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_x", x, 316);
    check("rst_y", y, 236);
    check("rst_right", right, 324);
    check("rst_bottom", bottom, 244);
    check("rst_goal_l", goal_l, 0);
    check("rst_goal_r", goal_r, 0);
    check("rst_serving", serving, 0);
    check("rst_speed", speed, 16);
    check("rst_w_y", w_y, 20);
    rst_n = 1'b1;
    @(negedge clk);

    // Serve timing and first launch (rnd 0: vx +16, vy 0)
    game_en = 1'b1;
    @(negedge clk);
    check("serve_enter", serving, 1);
    not_serving = 0;
    for (int i = 0; i < 60; i++) begin
      frame();
      if (!serving) not_serving++;
    end
    check("serve_hold_60", not_serving, 0);
    frame();
    check("launch_serving", serving, 0);
    check("launch_x", x, 316);
    frame();
    frame();
    check("move_x", x, 318);
    check("move_right", right, 326);
    check("move_y", y, 236);

    // game_en dropped mid-flight
    game_en = 1'b0;
    @(negedge clk);
    check("drop_x", x, 316);
    check("drop_serving", serving, 0);
    check("drop_goal_l", goal_l, 0);
    check("drop_goal_r", goal_r, 0);

    // Top wall: vx +16, vy -3 sixteenths; short screen starts at y 20.0
    serve(8'h16);
    y_min = 1000;
    for (int i = 1; i <= 60; i++) begin
      frame();
      if (w_y < y_min) y_min = w_y;
      if (i == 54) check("wall_y_54", w_y, 9);
      if (i == 55) check("wall_y_55", w_y, 10);
    end
    check("wall_y_min", y_min, 9);
    check("wall_y_60", w_y, 11);
    check("wall_bottom_60", w_bottom, 19);
    check("drift_x_60", x, 376);
    check("drift_y_60", y, 224);

    // Paddle hits: launch leftwards, then left-paddle edges
    serve(8'h01);
    frame();
    check("hit_pre_x", x, 315);
    hit(1'b1, 5);
    frame();
    check("hit_first_x", x, 316);
    check("hit_first_speed", speed, 16);
    hit(1'b1, 4);
    hit(1'b1, 2);
    check("hit_held_speed", speed, 16);
    hit(1'b1, 3);
    check("hit_fourth_speed", speed, 18);
    for (int k = 5; k <= 100; k++) begin
      hit(k % 2 == 0, 1);
      if (k == 92) check("hit_92_speed", speed, 62);
    end
    check("hit_100_speed", speed, 64);
    frame();
    check("hit_max_x", x, 320);

    // Left goal after a speed-up
    serve(8'h01);
    hit(1'b1, 1);
    hit(1'b0, 1);
    hit(1'b1, 1);
    hit(1'b0, 1);
    check("goal_pre_speed", speed, 18);
    repeat (307) frame();
    check("goal_pre_x", x, 9);
    check("goal_pre_pulse", goal_l, 0);
    frame();
    check("goal_pulse_l", goal_l, 1);
    check("goal_pulse_r", goal_r, 0);
    check("goal_hold_x", x, 9);
    @(negedge clk);
    check("goal_end_pulse", goal_l, 0);
    check("goal_centre_x", x, 316);
    check("goal_serving", serving, 1);
    check("goal_speed", speed, 16);

    // Asynchronous reset mid-flight
    serve(8'h00);
    repeat (4) hit(1'b1, 1);
    repeat (5) frame();
    check("arst_pre_x", x, 321);
    check("arst_pre_speed", speed, 18);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", x, 316);
    check("arst_speed", speed, 16);
    check("arst_serving", serving, 0);
    check("arst_goal_l", goal_l, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
